// File: rtl/turn_controller.sv
// turn_controller
//   Sequences the throw mechanic shared by the cat and dog players. Space is routed to the
//   active player's power bar. On release, that bar's force is captured and a one-cycle launch
//   is issued. The turn passes to the other player once the projectile lands.
//
// Optional feature (macro TURN_TIMEOUT_EN):
//   When defined, a turn left idle in ARMED for TIMEOUT_CYCLES cycles is forfeited.
//   When undefined, ARMED waits indefinitely and turn_timeout is tied low.
//
// Parameters:
//   MIN_FORCE       captured forces below this value are misfires (no launch)
//   TIMEOUT_CYCLES  ARMED idle limit, used only with TURN_TIMEOUT_EN
//
// Ports:
//   clk           pixel clock, all logic on posedge
//   rst           synchronous active-high reset
//   space         space-key level, synchronous to clk
//   force_cat     throw_force from the cat power bar
//   force_dog     throw_force from the dog power bar
//   proj_done     one-cycle pulse: projectile landed / left the screen
//   game_over     level: a player has been defeated
//   space_cat     gated space to the cat bar (combinational)
//   space_dog     gated space to the dog bar (combinational)
//   turn          active player, 0 = cat, 1 = dog
//   launch        one-cycle launch pulse
//   launch_force  force of the last launch, held between launches
//   turn_timeout  one-cycle pulse when a turn is forfeited
module turn_controller #(
    parameter int unsigned MIN_FORCE      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 650_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       space,
    input  logic [9:0] force_cat,
    input  logic [9:0] force_dog,
    input  logic       proj_done,
    input  logic       game_over,
    output logic       space_cat,
    output logic       space_dog,
    output logic       turn,
    output logic       launch,
    output logic [9:0] launch_force,
    output logic       turn_timeout
);

    typedef enum logic [2:0] {
        StArmed,
        StCharge,
        StCapture,
        StFlight,
        StOver
    } state_e;

    state_e     state_q;
    logic       space_q;
    // Set once space has been seen low since reset. A key held through reset release must be
    // dropped and pressed again before it can start a charge.
    logic       rel_seen_q;
    logic       turn_q;
    logic       launch_q;
    logic [9:0] launch_force_q;
    logic       timeout_q;

    logic       press;
    logic [9:0] sel_force;
    logic       force_ok;

    assign press     = space && !space_q && rel_seen_q;
    assign sel_force = turn_q ? force_dog : force_cat;
    assign force_ok  = {22'd0, sel_force} >= MIN_FORCE;

`ifdef TURN_TIMEOUT_EN
    logic [31:0] idle_cnt_q;
    logic        idle_hit;

    assign idle_hit = (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StArmed;
            space_q        <= 1'b0;
            rel_seen_q     <= 1'b0;
            turn_q         <= 1'b0;
            launch_q       <= 1'b0;
            launch_force_q <= '0;
            timeout_q      <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            idle_cnt_q     <= '0;
`endif
        end else begin
            space_q   <= space;
            launch_q  <= 1'b0;
            timeout_q <= 1'b0;
            if (!space) begin
                rel_seen_q <= 1'b1;
            end
`ifdef TURN_TIMEOUT_EN
            // Counter only runs in ARMED; every other path leaves it cleared.
            idle_cnt_q <= '0;
`endif
            if (game_over) begin
                state_q <= StOver;
            end else begin
                unique case (state_q)
                    StArmed: begin
                        if (press) begin
                            state_q <= StCharge;
                        end
`ifdef TURN_TIMEOUT_EN
                        else if (idle_hit) begin
                            turn_q    <= ~turn_q;
                            timeout_q <= 1'b1;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 32'd1;
                        end
`endif
                    end
                    StCharge: begin
                        // The bar registers its force on this same edge.
                        if (!space) begin
                            state_q <= StCapture;
                        end
                    end
                    StCapture: begin
                        if (force_ok) begin
                            state_q        <= StFlight;
                            launch_q       <= 1'b1;
                            launch_force_q <= sel_force;
                        end else begin
                            state_q <= StArmed;
                        end
                    end
                    StFlight: begin
                        if (proj_done) begin
                            state_q <= StArmed;
                            turn_q  <= ~turn_q;
                        end
                    end
                    StOver: begin
                        state_q <= StOver;
                    end
                    default: begin
                        state_q <= StArmed;
                    end
                endcase
            end
        end
    end

    assign space_cat    = space && (state_q == StCharge) && !turn_q;
    assign space_dog    = space && (state_q == StCharge) && turn_q;
    assign turn         = turn_q;
    assign launch       = launch_q;
    assign launch_force = launch_force_q;
`ifdef TURN_TIMEOUT_EN
    assign turn_timeout = timeout_q;
`else
    assign turn_timeout = 1'b0;
`endif

endmodule
